// File: rtl/beta_if_prefetch_buffer_pkg.sv
// Shared types and constants for the beta IF-stage prefetch buffer.
// Imported by the interface, the FIFO and the top.
package beta_if_prefetch_buffer_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef logic [31:0] instr_word_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_RUN,
        PF_STOP
    } prefetch_state_e;

endpackage

// File: rtl/beta_if_prefetch_buffer_if.sv
// Memory fetch bus (req/gnt/rvalid) plus decode handshake of the prefetch buffer.
// Handshakes: a request is accepted on req&gnt, and req/addr hold until then; decode consumes the head on valid&ready.
interface beta_if_prefetch_buffer_if;
    import beta_if_prefetch_buffer_pkg::*;

    logic              instr_req_o;
    logic [XLEN-1:0]   instr_addr_o;
    logic              instr_gnt_i;
    logic              instr_rvalid_i;
    instr_word_t       instr_rdata_i;
    logic              instr_valid_o;
    instr_word_t       instr_rdata_o;
    logic [XLEN-1:0]   pc_o;
    logic              instr_ready_i;

    modport master (
        output instr_req_o, instr_addr_o, instr_valid_o, instr_rdata_o, pc_o,
        input  instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );

    modport slave (
        input  instr_req_o, instr_addr_o, instr_valid_o, instr_rdata_o, pc_o,
        output instr_gnt_i, instr_rvalid_i, instr_rdata_i, instr_ready_i
    );

endinterface

// File: rtl/beta_sync_fifo.sv
// Single-clock FIFO with flush; simultaneous push and pop is legal even when full.
// The head word reads as zero while empty so idle outputs stay quiet.
module beta_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

endmodule

// File: rtl/beta_if_prefetch_buffer.sv
// Instruction prefetch unit: credit-limited word fetches into a FIFO, presented to decode as {pc, instr}.
// A branch flushes the FIFO and marks every in-flight response of the old path for discard.
module beta_if_prefetch_buffer
    import beta_if_prefetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       fetch_en_i,
    input  logic [XLEN-1:0]            boot_addr_i,
    input  logic                       branch_i,
    input  logic [XLEN-1:0]            branch_addr_i,
    beta_if_prefetch_buffer_if.master  bus,
    output logic                       busy_o,
    output prefetch_state_e            state_o
);

    localparam int unsigned    CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]  MAX_W   = CW'(MAX_OUTSTANDING);
    localparam logic [XLEN-1:0] STEP   = XLEN'(INSTR_BYTES);

    prefetch_state_e state_q, state_d;
    logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            hold_q, hold_d;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     inflight;
    logic            fifo_full, fifo_empty;
    logic            req, grant, push, pop, start;
    logic [XLEN-1:0] branch_tgt, boot_tgt;
    logic [3:0]      unused_addr_bits;

    assign unused_addr_bits = {branch_addr_i[1:0], boot_addr_i[1:0]};
    assign branch_tgt       = {branch_addr_i[XLEN-1:2], 2'b00};
    assign boot_tgt         = {boot_addr_i[XLEN-1:2], 2'b00};

    assign inflight = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign req      = hold_q
                   || ((state_q == PF_RUN) && (inflight < DEPTH_W) && (outstanding_q < MAX_W));
    assign grant    = req && bus.instr_gnt_i;
    assign hold_d   = req && !bus.instr_gnt_i;

    // Responses still owed to the old path are dropped here, never pushed.
    assign push  = bus.instr_rvalid_i && !branch_i && (discard_q == '0);
    assign pop   = !fifo_empty && bus.instr_ready_i && !branch_i;
    assign start = (state_q == PF_IDLE) && (state_d == PF_RUN);

    assign outstanding_d = outstanding_q + {{(CW-1){1'b0}}, grant}
                                         - {{(CW-1){1'b0}}, bus.instr_rvalid_i};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PF_IDLE: if (fetch_en_i && !branch_i) state_d = PF_RUN;
            PF_RUN:  if (!fetch_en_i && (!req || bus.instr_gnt_i)) state_d = PF_STOP;
            PF_STOP: if ((outstanding_q == '0) && !branch_i) state_d = PF_IDLE;
            default: state_d = PF_IDLE;
        endcase
    end

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        pc_d         = pc_q;
        discard_d    = discard_q;
        if (branch_i) begin
            fetch_addr_d = branch_tgt;
            pc_d         = branch_tgt;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d    = outstanding_d;
        end else begin
            if (start) begin
                fetch_addr_d = boot_tgt;
                pc_d         = boot_tgt;
            end else begin
                if (grant) fetch_addr_d = fetch_addr_q + STEP;
                if (pop)   pc_d         = pc_q + STEP;
            end
            if (bus.instr_rvalid_i && (discard_q != '0)) discard_d = discard_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= PF_IDLE;
            fetch_addr_q  <= '0;
            pc_q          <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            hold_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_addr_q  <= fetch_addr_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            hold_q        <= hold_d;
        end
    end

    beta_sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (branch_i),
        .push_i  (push),
        .data_i  (bus.instr_rdata_i),
        .pop_i   (pop),
        .data_o  (bus.instr_rdata_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.instr_req_o   = req;
    assign bus.instr_addr_o  = fetch_addr_q;
    assign bus.instr_valid_o = !fifo_empty;
    assign bus.pc_o          = pc_q;
    assign busy_o            = (state_q != PF_IDLE) || (outstanding_q != '0);
    assign state_o           = state_q;

    no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && fifo_full && !pop));
    credit_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (discard_q <= outstanding_q) && (outstanding_q <= MAX_W));

endmodule

// File: tb/tb_beta_if_prefetch_buffer.sv
// Directed bench for the prefetch buffer: a queue-based memory answers grants one cycle later
// (gated by resp_en), and each scenario task checks hand-computed values inline.
module tb_beta_if_prefetch_buffer;
    import beta_if_prefetch_buffer_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            fetch_en;
    logic [31:0]     boot_addr;
    logic            branch;
    logic [31:0]     branch_addr;
    logic            busy;
    prefetch_state_e state;

    logic            resp_en;
    logic [31:0]     mem_q[$];
    logic [31:0]     gaddr_q[$];
    int              grants;
    int              total;
    int              bad;

    beta_if_prefetch_buffer_if bus();

    beta_if_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .fetch_en_i    (fetch_en),
        .boot_addr_i   (boot_addr),
        .branch_i      (branch),
        .branch_addr_i (branch_addr),
        .bus           (bus),
        .busy_o        (busy),
        .state_o       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data word for address a is ~a; response one cycle after grant when enabled.
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            mem_q.delete();
            gaddr_q.delete();
            grants = 0;
            bus.instr_rvalid_i = 1'b0;
            bus.instr_rdata_i  = '0;
        end else begin
            if (resp_en && mem_q.size() > 0) begin
                bus.instr_rvalid_i = 1'b1;
                bus.instr_rdata_i  = ~mem_q.pop_front();
            end else begin
                bus.instr_rvalid_i = 1'b0;
                bus.instr_rdata_i  = '0;
            end
            if (bus.instr_req_o && bus.instr_gnt_i) begin
                mem_q.push_back(bus.instr_addr_o);
                gaddr_q.push_back(bus.instr_addr_o);
                grants++;
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        boot_addr = '0;
        branch = 1'b0;
        branch_addr = '0;
        resp_en = 1'b0;
        bus.instr_gnt_i = 1'b0;
        bus.instr_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (bus.instr_req_o !== 1'b0) begin bad++; $display("FAIL reset_req: got %0h exp 0", bus.instr_req_o); end
        total++; if (bus.instr_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr: got %0h exp 0", bus.instr_addr_o); end
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h exp 0", bus.instr_valid_o); end
        total++; if (bus.instr_rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %0h exp 0", bus.instr_rdata_o); end
        total++; if (bus.pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc: got %0h exp 0", bus.pc_o); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0h exp 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (state !== PF_IDLE) begin bad++; $display("FAIL reset_state: got %0d exp %0d", state, PF_IDLE); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        bus.instr_gnt_i = 1'b1;
        resp_en = 1'b1;
        bus.instr_ready_i = 1'b1;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL stream_latency: got %0h exp 0", bus.instr_valid_o); end
        @(negedge clk);
        exp_pc = 32'h0000_1000;
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.instr_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid%0d: got %0h exp 1", k, bus.instr_valid_o); end
            total++; if (bus.pc_o !== exp_pc) begin bad++; $display("FAIL stream_pc%0d: got %0h exp %0h", k, bus.pc_o, exp_pc); end
            total++; if (bus.instr_rdata_o !== ~exp_pc) begin bad++; $display("FAIL stream_data%0d: got %0h exp %0h", k, bus.instr_rdata_o, ~exp_pc); end
            exp_pc = exp_pc + 32'd4;
            @(negedge clk);
        end
        fetch_en = 1'b0;
        for (int c = 0; c < 40 && !(state == PF_IDLE && !bus.instr_valid_o); c++) @(negedge clk);
        total++; if (state !== PF_IDLE) begin bad++; $display("FAIL stream_stop_state: got %0d exp %0d", state, PF_IDLE); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL stream_stop_busy: got %0h exp 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        int n;
        int req_high;
        do_reset();
        bus.instr_gnt_i = 1'b1;
        resp_en = 1'b1;
        bus.instr_ready_i = 1'b0;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        repeat (12) @(negedge clk);
        total++; if (grants != 4) begin bad++; $display("FAIL full_grants: got %0d exp 4", grants); end
        total++; if (bus.pc_o !== 32'h0000_1000) begin bad++; $display("FAIL full_pc: got %0h exp 1000", bus.pc_o); end
        req_high = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.instr_req_o !== 1'b0) req_high++;
            @(negedge clk);
        end
        total++; if (req_high != 0) begin bad++; $display("FAIL full_req_low: got %0d high cycles exp 0", req_high); end
        total++; if (grants != 4) begin bad++; $display("FAIL full_no_extra: got %0d exp 4", grants); end
        bus.instr_ready_i = 1'b1;
        exp_pc = 32'h0000_1000;
        n = 0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            if (bus.instr_valid_o) begin
                total++; if (bus.pc_o !== exp_pc) begin bad++; $display("FAIL resume_pc%0d: got %0h exp %0h", n, bus.pc_o, exp_pc); end
                total++; if (bus.instr_rdata_o !== ~exp_pc) begin bad++; $display("FAIL resume_data%0d: got %0h exp %0h", n, bus.instr_rdata_o, ~exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            @(negedge clk);
        end
        total++; if (n != 6) begin bad++; $display("FAIL resume_count: got %0d exp 6", n); end
    endtask

    task automatic test_branch_drop();
        int waited;
        do_reset();
        bus.instr_gnt_i = 1'b1;
        resp_en = 1'b0;
        bus.instr_ready_i = 1'b1;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        waited = 0;
        while (grants < 2 && waited < 20) begin @(negedge clk); waited++; end
        total++; if (grants != 2) begin bad++; $display("FAIL drop_grants: got %0d exp 2", grants); end
        total++; if (bus.instr_req_o !== 1'b0) begin bad++; $display("FAIL drop_req_credit: got %0h exp 0", bus.instr_req_o); end
        branch = 1'b1;
        branch_addr = 32'h0000_2002;
        @(negedge clk);
        branch = 1'b0;
        total++; if (bus.instr_addr_o !== 32'h0000_2000) begin bad++; $display("FAIL drop_addr: got %0h exp 2000", bus.instr_addr_o); end
        total++; if (bus.pc_o !== 32'h0000_2000) begin bad++; $display("FAIL drop_pc: got %0h exp 2000", bus.pc_o); end
        resp_en = 1'b1;
        for (int c = 0; c < 30 && !bus.instr_valid_o; c++) @(negedge clk);
        total++; if (bus.pc_o !== 32'h0000_2000) begin bad++; $display("FAIL drop_head_pc: got %0h exp 2000", bus.pc_o); end
        total++; if (bus.instr_rdata_o !== ~32'h0000_2000) begin bad++; $display("FAIL drop_head_data: got %0h exp %0h", bus.instr_rdata_o, ~32'h0000_2000); end
        total++; if (gaddr_q.size() < 3 || gaddr_q[2] !== 32'h0000_2000) begin bad++; $display("FAIL drop_req_addr: got %0d grants exp third at 2000", gaddr_q.size()); end
    endtask

    task automatic test_branch_collide();
        int waited;
        logic [31:0] exp_pc;
        int n;
        do_reset();
        bus.instr_gnt_i = 1'b1;
        resp_en = 1'b0;
        bus.instr_ready_i = 1'b0;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        waited = 0;
        while (grants < 2 && waited < 20) begin @(negedge clk); waited++; end
        bus.instr_gnt_i = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        resp_en = 1'b0;
        @(negedge clk);
        total++; if (bus.instr_valid_o !== 1'b1 || bus.pc_o !== 32'h0000_1000) begin bad++; $display("FAIL collide_setup: got valid=%0h pc=%0h exp valid=1 pc=1000", bus.instr_valid_o, bus.pc_o); end
        branch = 1'b1;
        branch_addr = 32'h0000_3000;
        bus.instr_ready_i = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        branch = 1'b0;
        bus.instr_ready_i = 1'b0;
        total++; if (bus.instr_valid_o !== 1'b0) begin bad++; $display("FAIL collide_empty: got %0h exp 0", bus.instr_valid_o); end
        total++; if (bus.pc_o !== 32'h0000_3000) begin bad++; $display("FAIL collide_pc: got %0h exp 3000", bus.pc_o); end
        total++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0000_3000) begin bad++; $display("FAIL collide_req: got req=%0h addr=%0h exp req=1 addr=3000", bus.instr_req_o, bus.instr_addr_o); end
        bus.instr_gnt_i = 1'b1;
        bus.instr_ready_i = 1'b1;
        exp_pc = 32'h0000_3000;
        n = 0;
        for (int c = 0; c < 30 && n < 2; c++) begin
            if (bus.instr_valid_o) begin
                total++; if (bus.pc_o !== exp_pc || bus.instr_rdata_o !== ~exp_pc) begin bad++; $display("FAIL collide_head%0d: got pc=%0h data=%0h exp pc=%0h data=%0h", n, bus.pc_o, bus.instr_rdata_o, exp_pc, ~exp_pc); end
                exp_pc = exp_pc + 32'd4;
                n++;
            end
            @(negedge clk);
        end
        total++; if (n != 2) begin bad++; $display("FAIL collide_count: got %0d exp 2", n); end
    endtask

    task automatic test_gnt_stall();
        do_reset();
        bus.instr_gnt_i = 1'b0;
        resp_en = 1'b1;
        bus.instr_ready_i = 1'b0;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 1) fetch_en = 1'b0;
            total++; if (bus.instr_req_o !== 1'b1 || bus.instr_addr_o !== 32'h0000_1000) begin bad++; $display("FAIL stall_hold%0d: got req=%0h addr=%0h exp req=1 addr=1000", c, bus.instr_req_o, bus.instr_addr_o); end
        end
        total++; if (state !== PF_RUN) begin bad++; $display("FAIL stall_run: got %0d exp %0d", state, PF_RUN); end
        bus.instr_gnt_i = 1'b1;
        @(negedge clk);
        bus.instr_gnt_i = 1'b0;
        total++; if (state !== PF_STOP) begin bad++; $display("FAIL stall_stop: got %0d exp %0d", state, PF_STOP); end
        total++; if (bus.instr_req_o !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL stall_stop_io: got req=%0h busy=%0h exp req=0 busy=1", bus.instr_req_o, busy); end
        for (int c = 0; c < 20 && state != PF_IDLE; c++) @(negedge clk);
        total++; if (state !== PF_IDLE || busy !== 1'b0) begin bad++; $display("FAIL stall_idle: got state=%0d busy=%0h exp state=0 busy=0", state, busy); end
        total++; if (bus.instr_valid_o !== 1'b1 || bus.instr_rdata_o !== ~32'h0000_1000) begin bad++; $display("FAIL stall_keep: got valid=%0h data=%0h exp valid=1 data=%0h", bus.instr_valid_o, bus.instr_rdata_o, ~32'h0000_1000); end
    endtask

    task automatic test_reset_mid();
        int waited;
        do_reset();
        bus.instr_gnt_i = 1'b1;
        resp_en = 1'b0;
        bus.instr_ready_i = 1'b0;
        boot_addr = 32'h0000_1000;
        fetch_en = 1'b1;
        waited = 0;
        while (grants < 2 && waited < 20) begin @(negedge clk); waited++; end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %0h exp 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.instr_req_o !== 1'b0 || bus.instr_addr_o !== 32'h0 || bus.pc_o !== 32'h0) begin bad++; $display("FAIL mid_bus: got req=%0h addr=%0h pc=%0h exp 0", bus.instr_req_o, bus.instr_addr_o, bus.pc_o); end
        total++; if (bus.instr_valid_o !== 1'b0 || bus.instr_rdata_o !== 32'h0 || busy !== 1'b0) begin bad++; $display("FAIL mid_out: got valid=%0h data=%0h busy=%0h exp 0", bus.instr_valid_o, bus.instr_rdata_o, busy); end
        total++; if (state !== PF_IDLE) begin bad++; $display("FAIL mid_state: got %0d exp %0d", state, PF_IDLE); end
        @(negedge clk);
        rst_n = 1'b1;
        fetch_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_drop();
        test_branch_collide();
        test_gnt_stall();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
